// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls,
// MEM-resolved redirects, data-memory freezes and saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_redirect,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LU     = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic lu;
    logic sel_busy;
    logic sel_redir;
    logic sel_lu;
    logic stall_inc;
    logic flush_inc;

    assign lu = ex_MemRead && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Mutually exclusive selects encode the fixed priority rst > busy > redirect > lu
    assign sel_busy  = !rst && mem_busy;
    assign sel_redir = !rst && !mem_busy && mem_redirect;
    assign sel_lu    = !rst && !mem_busy && !mem_redirect && lu && (state != LU);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_hold    = 1'b0;
        state_nx     = RUN;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        unique case (1'b1)
            rst: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            sel_busy: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                state_nx    = FREEZE;
                stall_inc   = 1'b1;
            end
            sel_redir: begin
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_inc    = 1'b1;
            end
            sel_lu: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                state_nx    = LU;
                stall_inc   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nx;
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl; a second CNT_W=2 instance
// shares the stimulus and exposes counter saturation.
module tb_hazard_ctrl;

    typedef struct {
        int         r;
        int         rs;
        int         rt;
        int         uses;
        int         mr;
        int         ert;
        int         redir;
        int         busy;
        logic [5:0] ctl;
        int         sc;
        int         fc;
    } row_t;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [5:0]  ctl2;
        logic [1:0]  sc2;
        logic [1:0]  fc2;
    } exp_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
    localparam logic [5:0] NORM  = 6'b110000;
    localparam logic [5:0] RSTC  = 6'b001110;
    localparam logic [5:0] STALL = 6'b000100;
    localparam logic [5:0] REDIR = 6'b101110;
    localparam logic [5:0] HOLD  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_MemRead, mem_redirect, mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold;
    logic [15:0] stall_count, flush_count;
    logic        pc_write2, if_id_write2, if_id_flush2, id_ex_flush2, ex_mem_flush2, pipe_hold2;
    logic [1:0]  stall_count2, flush_count2;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
        .mem_redirect(mem_redirect), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
        .mem_redirect(mem_redirect), .mem_busy(mem_busy),
        .pc_write(pc_write2), .if_id_write(if_id_write2),
        .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2),
        .ex_mem_flush(ex_mem_flush2), .pipe_hold(pipe_hold2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    task automatic drive(input row_t r);
        rst          = (r.r != 0);
        id_rs        = 5'(r.rs);
        id_rt        = 5'(r.rt);
        id_uses_rt   = (r.uses != 0);
        ex_MemRead   = (r.mr != 0);
        ex_rt        = 5'(r.ert);
        mem_redirect = (r.redir != 0);
        mem_busy     = (r.busy != 0);
    endtask

    function automatic exp_t mk(input row_t r);
        exp_t e;
        e.ctl  = r.ctl;
        e.ctl2 = r.ctl;
        e.sc   = 16'(r.sc);
        e.fc   = 16'(r.fc);
        e.sc2  = (r.sc > 3) ? 2'd3 : 2'(r.sc);
        e.fc2  = (r.fc > 3) ? 2'd3 : 2'(r.fc);
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g.ctl  = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold};
        g.sc   = stall_count;
        g.fc   = flush_count;
        g.ctl2 = {pc_write2, if_id_write2, if_id_flush2, id_ex_flush2, ex_mem_flush2, pipe_hold2};
        g.sc2  = stall_count2;
        g.fc2  = flush_count2;
        return g;
    endfunction

    task automatic do_reset();
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; ex_MemRead = 1'b0; mem_redirect = 1'b0; mem_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        row_t rows [3];
        exp_t e, g;
        rows = '{
            '{1, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 0},
            '{1, 8, 0, 0, 1, 8, 1, 1, RSTC, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t rows [5];
        exp_t e, g;
        do_reset();
        rows = '{
            '{0, 8, 0, 0, 1, 8, 0, 0, STALL, 0, 0},
            '{0, 8, 0, 0, 1, 8, 0, 0, NORM,  1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  1, 0},
            '{0, 3, 8, 1, 1, 8, 0, 0, STALL, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  2, 0}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_false_hazard();
        row_t rows [5];
        exp_t e, g;
        do_reset();
        rows = '{
            '{0, 0, 0, 1, 1, 0, 0, 0, NORM,  0, 0},
            '{0, 3, 9, 0, 1, 9, 0, 0, NORM,  0, 0},
            '{0, 8, 0, 0, 0, 8, 0, 0, NORM,  0, 0},
            '{0, 3, 9, 1, 1, 9, 0, 0, STALL, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  1, 0}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL no_false[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_lu();
        row_t rows [5];
        exp_t e, g;
        do_reset();
        rows = '{
            '{0, 8, 0, 0, 1, 8, 1, 0, REDIR, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 1},
            '{0, 8, 0, 0, 1, 8, 0, 0, STALL, 0, 1},
            '{0, 8, 0, 0, 1, 8, 1, 0, REDIR, 1, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  1, 2}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL redirect[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze();
        row_t rows [9];
        exp_t e, g;
        do_reset();
        rows = '{
            '{0, 0, 0, 0, 0, 0, 1, 1, HOLD,  0, 0},
            '{0, 0, 0, 0, 0, 0, 1, 1, HOLD,  1, 0},
            '{0, 0, 0, 0, 0, 0, 1, 1, HOLD,  2, 0},
            '{0, 0, 0, 0, 0, 0, 1, 0, REDIR, 3, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  3, 1},
            '{0, 5, 0, 0, 1, 5, 0, 1, HOLD,  3, 1},
            '{0, 5, 0, 0, 1, 5, 0, 0, STALL, 4, 1},
            '{0, 5, 0, 0, 1, 5, 0, 0, NORM,  5, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  5, 1}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL freeze[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows [6];
        exp_t e, g;
        do_reset();
        rows = '{
            '{0, 7, 0, 0, 1, 7, 0, 0, STALL, 0, 0},
            '{0, 7, 0, 0, 1, 7, 0, 0, NORM,  1, 0},
            '{0, 2, 7, 1, 1, 7, 0, 0, STALL, 1, 0},
            '{0, 2, 7, 1, 1, 7, 0, 1, HOLD,  2, 0},
            '{0, 2, 7, 1, 1, 7, 0, 0, STALL, 3, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  4, 0}};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        row_t rows [14];
        exp_t e, g;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rows[2*k]   = '{0, 8, 0, 0, 1, 8, 0, 0, STALL, k,     0};
            rows[2*k+1] = '{0, 8, 0, 0, 1, 8, 0, 0, NORM,  k + 1, 0};
        end
        rows[10] = '{0, 0, 0, 0, 0, 0, 0, 1, HOLD,  5, 0};
        rows[11] = '{1, 8, 0, 0, 1, 8, 1, 1, RSTC,  6, 0};
        rows[12] = '{0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0};
        rows[13] = '{0, 8, 0, 0, 1, 8, 0, 0, STALL, 0, 0};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back(mk(rows[i]));
            #2;
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL saturation[%0d]: got ctl=%b sc=%0d fc=%0d ctl2=%b sc2=%0d fc2=%0d, expected ctl=%b sc=%0d fc=%0d sc2=%0d fc2=%0d",
                         i, g.ctl, g.sc, g.fc, g.ctl2, g.sc2, g.fc2, e.ctl, e.sc, e.fc, e.sc2, e.fc2);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; ex_MemRead = 1'b0; mem_redirect = 1'b0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_redirect_lu();
        test_freeze();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
